// File: rtl/computer_pkg.sv
// -----------------------------------------------------------------------------
// computer_pkg
//   Shared definitions for the 8-bit computer control path:
//   - opcode values
//   - FSM state encoding
//   - ALU_Sel, Bus1_Sel and Bus2_Sel codes
//   - CCR flag bit positions
//   - small helpers that decode which register / ALU op an opcode targets
// -----------------------------------------------------------------------------
package computer_pkg;

  // Loads and stores
  localparam logic [7:0] OP_LDA_IMM = 8'h86;
  localparam logic [7:0] OP_LDA_DIR = 8'h87;
  localparam logic [7:0] OP_LDB_IMM = 8'h88;
  localparam logic [7:0] OP_LDB_DIR = 8'h89;
  localparam logic [7:0] OP_STA_DIR = 8'h96;
  localparam logic [7:0] OP_STB_DIR = 8'h97;

  // Two-operand ALU ops (result to A)
  localparam logic [7:0] OP_ADD_AB  = 8'h42;
  localparam logic [7:0] OP_SUB_AB  = 8'h43;
  localparam logic [7:0] OP_AND_AB  = 8'h44;
  localparam logic [7:0] OP_OR_AB   = 8'h45;

  // Single-register increment / decrement
  localparam logic [7:0] OP_INCA    = 8'h46;
  localparam logic [7:0] OP_INCB    = 8'h47;
  localparam logic [7:0] OP_DECA    = 8'h48;
  localparam logic [7:0] OP_DECB    = 8'h49;

  // Branches
  localparam logic [7:0] OP_BRA     = 8'h20;
  localparam logic [7:0] OP_BMI     = 8'h21;
  localparam logic [7:0] OP_BPL     = 8'h22;
  localparam logic [7:0] OP_BEQ     = 8'h23;
  localparam logic [7:0] OP_BNE     = 8'h24;
  localparam logic [7:0] OP_BVS     = 8'h25;
  localparam logic [7:0] OP_BVC     = 8'h26;
  localparam logic [7:0] OP_BCS     = 8'h27;
  localparam logic [7:0] OP_BCC     = 8'h28;

  // ALU_Sel codes
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_INC = 3'd4;
  localparam logic [2:0] ALU_DEC = 3'd5;

  // Bus1_Sel codes
  localparam logic [1:0] BUS1_PC = 2'd0;
  localparam logic [1:0] BUS1_A  = 2'd1;
  localparam logic [1:0] BUS1_B  = 2'd2;

  // Bus2_Sel codes
  localparam logic [1:0] BUS2_ALU  = 2'd0;
  localparam logic [1:0] BUS2_BUS1 = 2'd1;
  localparam logic [1:0] BUS2_MEM  = 2'd2;

  // CCR_Result = {N,Z,V,C}
  localparam int CCR_N = 3;
  localparam int CCR_Z = 2;
  localparam int CCR_V = 1;
  localparam int CCR_C = 0;

  // FSM states. OP4/OP5 fetch the operand byte address for every
  // memory-operand instruction; the branch-taken path keeps its own
  // states because its decision is made in D3, not in OP5.
  typedef enum logic [4:0] {
    S_F0   = 5'd0,
    S_F1   = 5'd1,
    S_F2   = 5'd2,
    S_D3   = 5'd3,
    S_OP4  = 5'd4,
    S_OP5  = 5'd5,
    S_LDI6 = 5'd6,
    S_LDD6 = 5'd7,
    S_LDD7 = 5'd8,
    S_LDD8 = 5'd9,
    S_STD6 = 5'd10,
    S_STD7 = 5'd11,
    S_ALU4 = 5'd12,
    S_IND4 = 5'd13,
    S_BRT4 = 5'd14,
    S_BRT5 = 5'd15,
    S_BRT6 = 5'd16,
    S_BRN4 = 5'd17,
    S_HALT = 5'd18
  } state_t;

  // True when the opcode's register operand is B rather than A.
  function automatic logic uses_reg_b(input logic [7:0] ir);
    logic b_s;
    case (ir)
      OP_LDB_IMM, OP_LDB_DIR, OP_STB_DIR, OP_INCB, OP_DECB: b_s = 1'b1;
      default:                                              b_s = 1'b0;
    endcase
    return b_s;
  endfunction

  // ALU operation implied by an ALU-class opcode.
  function automatic logic [2:0] alu_sel_for(input logic [7:0] ir);
    logic [2:0] sel_s;
    case (ir)
      OP_ADD_AB:        sel_s = ALU_ADD;
      OP_SUB_AB:        sel_s = ALU_SUB;
      OP_AND_AB:        sel_s = ALU_AND;
      OP_OR_AB:         sel_s = ALU_OR;
      OP_INCA, OP_INCB: sel_s = ALU_INC;
      OP_DECA, OP_DECB: sel_s = ALU_DEC;
      default:          sel_s = ALU_ADD;
    endcase
    return sel_s;
  endfunction

endpackage

// File: rtl/cu_branch_eval.sv
// -----------------------------------------------------------------------------
// cu_branch_eval
//   Combinational branch classifier.
//   Ports:
//     IR         in  8  opcode
//     CCR_Result in  4  flags {N,Z,V,C}
//     is_branch  out 1  opcode is one of the branch instructions
//     taken      out 1  branch condition holds (0 for non-branches)
// -----------------------------------------------------------------------------
module cu_branch_eval
  import computer_pkg::*;
(
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
  output logic       is_branch,
  output logic       taken
);

  // Decode the branch opcode and evaluate its flag condition.
  always_comb begin
    is_branch = 1'b1;
    taken     = 1'b0;
    case (IR)
      OP_BRA:  taken =  1'b1;
      OP_BMI:  taken =  CCR_Result[CCR_N];
      OP_BPL:  taken = ~CCR_Result[CCR_N];
      OP_BEQ:  taken =  CCR_Result[CCR_Z];
      OP_BNE:  taken = ~CCR_Result[CCR_Z];
      OP_BVS:  taken =  CCR_Result[CCR_V];
      OP_BVC:  taken = ~CCR_Result[CCR_V];
      OP_BCS:  taken =  CCR_Result[CCR_C];
      OP_BCC:  taken = ~CCR_Result[CCR_C];
      default: begin
        is_branch = 1'b0;
        taken     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//   Moore FSM that sequences the 8-bit computer datapath: fetch, decode and
//   one control word per execute state until the instruction retires.
//   Optional build macro: CU_ILLEGAL_TRAP_EN
//     defined   -> unknown opcode traps into HALT until reset; adds 'halted'
//     undefined -> unknown opcode behaves as a 1-byte NOP
//   Ports:
//     clk, reset (sync, active-high)
//     IR[7:0], CCR_Result[3:0] {N,Z,V,C}
//     IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write
//     ALU_Sel[2:0], Bus1_Sel[1:0], Bus2_Sel[1:0]
//     halted (only with CU_ILLEGAL_TRAP_EN)
// -----------------------------------------------------------------------------
module control_unit
  import computer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
  output logic       IR_Load,
  output logic       MAR_Load,
  output logic       PC_Load,
  output logic       PC_Inc,
  output logic       A_Load,
  output logic       B_Load,
  output logic [2:0] ALU_Sel,
  output logic       CCR_Load,
  output logic [1:0] Bus1_Sel,
  output logic [1:0] Bus2_Sel,
  output logic       write
`ifdef CU_ILLEGAL_TRAP_EN
  ,
  output logic       halted
`endif
);

  state_t state_r;
  state_t next_state_s;
  logic   is_branch_s;
  logic   taken_s;

  cu_branch_eval u_branch_eval (
    .IR         (IR),
    .CCR_Result (CCR_Result),
    .is_branch  (is_branch_s),
    .taken      (taken_s)
  );

  // State register with synchronous reset to FETCH_0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_F0;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; the branch decision is taken only in D3.
  always_comb begin
    next_state_s = S_F0;
    case (state_r)
      S_F0: next_state_s = S_F1;
      S_F1: next_state_s = S_F2;
      S_F2: next_state_s = S_D3;
      S_D3: begin
        if (is_branch_s) begin
          next_state_s = taken_s ? S_BRT4 : S_BRN4;
        end else begin
          case (IR)
            OP_LDA_IMM, OP_LDB_IMM, OP_LDA_DIR, OP_LDB_DIR,
            OP_STA_DIR, OP_STB_DIR:                   next_state_s = S_OP4;
            OP_ADD_AB, OP_SUB_AB, OP_AND_AB, OP_OR_AB: next_state_s = S_ALU4;
            OP_INCA, OP_INCB, OP_DECA, OP_DECB:        next_state_s = S_IND4;
`ifdef CU_ILLEGAL_TRAP_EN
            default:                                   next_state_s = S_HALT;
`else
            default:                                   next_state_s = S_F0;
`endif
          endcase
        end
      end
      S_OP4: next_state_s = S_OP5;
      // Operand address is in hand; the opcode chooses the remaining path.
      S_OP5: begin
        case (IR)
          OP_LDA_IMM, OP_LDB_IMM: next_state_s = S_LDI6;
          OP_LDA_DIR, OP_LDB_DIR: next_state_s = S_LDD6;
          OP_STA_DIR, OP_STB_DIR: next_state_s = S_STD6;
          default:                next_state_s = S_F0;
        endcase
      end
      S_LDD6: next_state_s = S_LDD7;
      S_LDD7: next_state_s = S_LDD8;
      S_STD6: next_state_s = S_STD7;
      S_BRT4: next_state_s = S_BRT5;
      S_BRT5: next_state_s = S_BRT6;
`ifdef CU_ILLEGAL_TRAP_EN
      S_HALT: next_state_s = S_HALT;
`else
      S_HALT: next_state_s = S_F0;
`endif
      // LDI6, LDD8, STD7, ALU4, IND4, BRT6, BRN4 retire; illegal codes recover.
      default: next_state_s = S_F0;
    endcase
  end

  // Output decode: control word per state (IR only refines selects/targets).
  always_comb begin
    IR_Load  = 1'b0;
    MAR_Load = 1'b0;
    PC_Load  = 1'b0;
    PC_Inc   = 1'b0;
    A_Load   = 1'b0;
    B_Load   = 1'b0;
    ALU_Sel  = ALU_ADD;
    CCR_Load = 1'b0;
    Bus1_Sel = BUS1_PC;
    Bus2_Sel = BUS2_ALU;
    write    = 1'b0;
    case (state_r)
      S_F0, S_OP4, S_BRT4: begin
        MAR_Load = 1'b1;
        Bus1_Sel = BUS1_PC;
        Bus2_Sel = BUS2_BUS1;
      end
      S_F1, S_OP5, S_BRN4: begin
        PC_Inc = 1'b1;
      end
      S_F2: begin
        IR_Load  = 1'b1;
        Bus2_Sel = BUS2_MEM;
      end
      S_LDD6, S_STD6: begin
        MAR_Load = 1'b1;
        Bus2_Sel = BUS2_MEM;
      end
      S_LDI6, S_LDD8: begin
        Bus2_Sel = BUS2_MEM;
        A_Load   = ~uses_reg_b(IR);
        B_Load   =  uses_reg_b(IR);
      end
      S_STD7: begin
        Bus1_Sel = uses_reg_b(IR) ? BUS1_B : BUS1_A;
        write    = 1'b1;
      end
      S_ALU4: begin
        ALU_Sel  = alu_sel_for(IR);
        Bus1_Sel = BUS1_B;
        Bus2_Sel = BUS2_ALU;
        A_Load   = 1'b1;
        CCR_Load = 1'b1;
      end
      S_IND4: begin
        ALU_Sel  = alu_sel_for(IR);
        Bus1_Sel = uses_reg_b(IR) ? BUS1_B : BUS1_A;
        Bus2_Sel = BUS2_ALU;
        A_Load   = ~uses_reg_b(IR);
        B_Load   =  uses_reg_b(IR);
        CCR_Load = 1'b1;
      end
      S_BRT6: begin
        PC_Load  = 1'b1;
        Bus2_Sel = BUS2_MEM;
      end
      // D3, LDD7, BRT5, HALT and illegal encodings drive nothing.
      default: begin
        IR_Load = 1'b0;
      end
    endcase
  end

`ifdef CU_ILLEGAL_TRAP_EN
  assign halted = (state_r == S_HALT);
`endif

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//   Directed self-checking bench for control_unit. Each cycle's full control
//   word is compared with a hand-written expected word.
//   Word layout: {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load,
//                 ALU_Sel[2:0], CCR_Load, Bus1_Sel[1:0], Bus2_Sel[1:0], write}
// -----------------------------------------------------------------------------
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ir;
  logic [3:0] ccr;
  logic       ir_load, mar_load, pc_load, pc_inc, a_load, b_load, ccr_load, wr;
  logic [2:0] alu_sel;
  logic [1:0] bus1_sel, bus2_sel;
`ifdef CU_ILLEGAL_TRAP_EN
  logic       halted;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  logic [14:0] w_f0, w_f1, w_f2, w_zero, w_mema, w_memb, w_marmem;
  logic [14:0] w_sta, w_stb, w_pcld, w_add, w_decb;

  control_unit dut (
    .clk        (clk),
    .reset      (reset),
    .IR         (ir),
    .CCR_Result (ccr),
    .IR_Load    (ir_load),
    .MAR_Load   (mar_load),
    .PC_Load    (pc_load),
    .PC_Inc     (pc_inc),
    .A_Load     (a_load),
    .B_Load     (b_load),
    .ALU_Sel    (alu_sel),
    .CCR_Load   (ccr_load),
    .Bus1_Sel   (bus1_sel),
    .Bus2_Sel   (bus2_sel),
    .write      (wr)
`ifdef CU_ILLEGAL_TRAP_EN
    ,
    .halted     (halted)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] mk(input logic irl, input logic marl,
                                     input logic pcl, input logic pci,
                                     input logic al, input logic bl,
                                     input logic [2:0] alu, input logic cl,
                                     input logic [1:0] b1, input logic [1:0] b2,
                                     input logic w);
    return {irl, marl, pcl, pci, al, bl, alu, cl, b1, b2, w};
  endfunction

  task automatic check_val(input string tag, input logic [15:0] obs,
                           input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample mid-cycle, then advance to just after the next rising edge.
  task automatic expect_cycle(input string tag, input logic [14:0] exp);
    @(negedge clk);
    check_val(tag, {1'b0, ir_load, mar_load, pc_load, pc_inc, a_load, b_load,
                    alu_sel, ccr_load, bus1_sel, bus2_sel, wr}, {1'b0, exp});
    @(posedge clk);
    #1;
  endtask

  // Common F0..D3 prefix of every instruction.
  task automatic fetch(input string tag, input logic [7:0] op,
                       input logic [3:0] flags);
    ir  = op;
    ccr = flags;
    expect_cycle({tag, "_c1"}, w_f0);
    expect_cycle({tag, "_c2"}, w_f1);
    expect_cycle({tag, "_c3"}, w_f2);
    expect_cycle({tag, "_c4"}, w_zero);
  endtask

  initial begin
    w_f0     = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 2'd1, 1'b0);
    w_f1     = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    w_f2     = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 2'd2, 1'b0);
    w_zero   = 15'd0;
    w_mema   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 2'd0, 2'd2, 1'b0);
    w_memb   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 2'd0, 2'd2, 1'b0);
    w_marmem = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 2'd2, 1'b0);
    w_sta    = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd1, 2'd0, 1'b1);
    w_stb    = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd2, 2'd0, 1'b1);
    w_pcld   = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 2'd2, 1'b0);
    w_add    = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 2'd2, 2'd0, 1'b0);
    w_decb   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 2'd2, 2'd0, 1'b0);

    // Reset held for two cycles, checked while still asserted.
    reset = 1'b1;
    ir    = 8'h00;
    ccr   = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    expect_cycle("reset", w_f0);
    reset = 1'b0;

    // LDA immediate: A_Load from memory in cycle 7.
    fetch("lda_imm", 8'h86, 4'h0);
    expect_cycle("lda_imm_c5", w_f0);
    expect_cycle("lda_imm_c6", w_f1);
    expect_cycle("lda_imm_c7", w_mema);

    // STA direct: single write cycle with Bus1 = A at cycle 8.
    fetch("sta_dir", 8'h96, 4'h0);
    expect_cycle("sta_dir_c5", w_f0);
    expect_cycle("sta_dir_c6", w_f1);
    expect_cycle("sta_dir_c7", w_marmem);
    expect_cycle("sta_dir_c8", w_sta);

    // BEQ taken; flags change after D3 must not matter.
    fetch("beq_t", 8'h23, 4'b0100);
    ccr = 4'b0000;
    expect_cycle("beq_t_c5", w_f0);
    expect_cycle("beq_t_c6", w_zero);
    expect_cycle("beq_t_c7", w_pcld);

    // BEQ not taken: skip operand with PC_Inc only.
    fetch("beq_n", 8'h23, 4'b0000);
    ccr = 4'b0100;
    expect_cycle("beq_n_c5", w_f1);

    // BCC with C set: not taken.
    fetch("bcc_n", 8'h28, 4'b0001);
    expect_cycle("bcc_n_c5", w_f1);

    // ADD A,B.
    fetch("add", 8'h42, 4'h0);
    expect_cycle("add_c5", w_add);

    // DECB.
    fetch("decb", 8'h49, 4'h0);
    expect_cycle("decb_c5", w_decb);

    // LDB direct: 9 cycles, B loaded in the last one.
    fetch("ldb_dir", 8'h89, 4'h0);
    expect_cycle("ldb_dir_c5", w_f0);
    expect_cycle("ldb_dir_c6", w_f1);
    expect_cycle("ldb_dir_c7", w_marmem);
    expect_cycle("ldb_dir_c8", w_zero);
    expect_cycle("ldb_dir_c9", w_memb);

    // Unknown opcode.
    fetch("illegal", 8'hFF, 4'h0);
`ifdef CU_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("halted", {15'd0, halted}, 16'd1);
      @(posedge clk);
      #1;
    end
    expect_cycle("halt_quiet", w_zero);
    reset = 1'b1;
    expect_cycle("halt_rst", w_zero);
    reset = 1'b0;
    @(negedge clk);
    check_val("halted_clr", {15'd0, halted}, 16'd0);
    @(posedge clk);
    #1;
    expect_cycle("post_halt_c2", w_f1);
    expect_cycle("post_halt_c3", w_f2);
    expect_cycle("post_halt_c4", w_zero);
`endif

    // STB direct with reset during the write cycle.
    fetch("stb_rst", 8'h97, 4'h0);
    expect_cycle("stb_rst_c5", w_f0);
    expect_cycle("stb_rst_c6", w_f1);
    expect_cycle("stb_rst_c7", w_marmem);
    reset = 1'b1;
    expect_cycle("stb_rst_c8", w_stb);
    reset = 1'b0;
    expect_cycle("stb_rst_f0", w_f0);
    expect_cycle("stb_rst_f1", w_f1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
